rv32_lsu_bus_bridge: RTL and testbench

//  Data-side stage directly downstream of the single-cycle core's memory port (address/MemRead/MemWrite/wdata/rdata).

---
 rtl/rv32_lsu_bus_bridge_pkg.sv | 58 +++++
 rtl/rv32_lsu_align.sv | 50 +++++
 rtl/rv32_lsu_bus_bridge.sv | 141 ++++++++++++++
 tb/tb_rv32_lsu_bus_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_lsu_bus_bridge_pkg
//  Brief    : Shared funct3 codes, FSM encoding and access-size helpers for
//             the LSU bus bridge and its alignment datapath.
//  Revision : 1.0  initial release
// ============================================================================
package rv32_lsu_bus_bridge_pkg;

   // Load/store funct3 codes (instruction[14:12])
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Bridge FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

   // Access size decoded from funct3
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_t;

   // Only the low two funct3 bits carry size; 011/110/111 fall into word.
   function automatic acc_size_t f3_size(input logic [2:0] f3);
      acc_size_t sz;
      case (f3[1:0])
         2'b00:   sz = SZ_BYTE;
         2'b01:   sz = SZ_HALF;
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   // Byte accesses can never be misaligned.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3_size(f3))
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = |lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_lsu_align
//  Brief    : Combinational store strobe/lane replication and load lane
//             extraction with sign/zero extension (32-bit data only).
//  Revision : 1.0  initial release
// ============================================================================
module rv32_lsu_align
   import rv32_lsu_bus_bridge_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Size-dependent strobe, replicated write data and extended read data
   always_comb begin
      w_byte    = load_word[{lane, 3'b000} +: 8];
      w_half    = lane[1] ? load_word[31:16] : load_word[15:0];
      wstrb     = 4'hF;
      wdata     = store_data;
      load_data = load_word;
      case (f3_size(funct3))
         SZ_BYTE: begin
            wstrb     = 4'b0001 << lane;
            wdata     = {4{store_data[7:0]}};
            load_data = funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            wstrb     = lane[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: begin
            wstrb     = 4'hF;
            wdata     = store_data;
            load_data = load_word;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv32_lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_lsu_bus_bridge
//  Brief    : Converts single-cycle core loads/stores into valid/ready
//             request + response bus transactions, stalling the core until
//             each access completes. Flags misaligned accesses and bus errors.
//  Revision : 1.0  initial release
// ============================================================================
module rv32_lsu_bus_bridge
   import rv32_lsu_bus_bridge_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] address,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [DW-1:0] wdata,
   input  logic [2:0]    funct3,
   output logic [DW-1:0] rdata,
   output logic          stall,
   output logic          misaligned,
   output logic          bus_err,
   output logic          bus_req_valid,
   input  logic          bus_req_ready,
   output logic [AW-1:0] bus_addr,
   output logic          bus_we,
   output logic [3:0]    bus_wstrb,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_rsp_valid,
   input  logic [DW-1:0] bus_rsp_rdata,
   input  logic          bus_rsp_err
);

   lsu_state_t    r_state;
   logic          r_valid;
   logic [AW-1:0] r_addr;
   logic          r_we;
   logic [3:0]    r_wstrb;
   logic [DW-1:0] r_wdata;
   logic [2:0]    r_funct3;
   logic [1:0]    r_lane;
   logic [DW-1:0] r_rdata;
   logic          r_err;

   logic          w_access;
   logic          w_mis;
   logic          w_idle;
   logic [2:0]    w_al_f3;
   logic [1:0]    w_al_lane;
   logic [3:0]    w_wstrb;
   logic [31:0]   w_wdata;
   logic [31:0]   w_load;

   assign w_access = MemRead | MemWrite;
   assign w_mis    = is_misaligned(funct3, address[1:0]);
   assign w_idle   = (r_state == ST_IDLE);

   // In IDLE the align block shapes the live store; afterwards it extracts
   // the response using the size/lane latched at launch.
   assign w_al_f3   = w_idle ? funct3       : r_funct3;
   assign w_al_lane = w_idle ? address[1:0] : r_lane;

   rv32_lsu_align u_align (
      .funct3     (w_al_f3),
      .lane       (w_al_lane),
      .store_data (wdata),
      .load_word  (bus_rsp_rdata),
      .wstrb      (w_wstrb),
      .wdata      (w_wdata),
      .load_data  (w_load)
   );

   // Transaction FSM: launch from IDLE, hold request in REQ, collect in WAIT
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_wstrb  <= 4'b0;
         r_wdata  <= '0;
         r_funct3 <= 3'b0;
         r_lane   <= 2'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_access && !w_mis) begin
                  r_state  <= ST_REQ;
                  r_valid  <= 1'b1;
                  r_addr   <= {address[AW-1:2], 2'b00};
                  r_we     <= MemWrite;
                  r_wstrb  <= MemWrite ? w_wstrb : 4'b0;
                  r_wdata  <= MemWrite ? w_wdata : '0;
                  r_funct3 <= funct3;
                  r_lane   <= address[1:0];
                  r_rdata  <= '0;
                  r_err    <= 1'b0;
               end
            end
            ST_REQ: begin
               if (bus_req_ready) begin
                  r_state <= ST_WAIT;
                  r_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (bus_rsp_valid) begin
                  r_state <= ST_DONE;
                  r_rdata <= bus_rsp_err ? '0 : w_load;
                  r_err   <= bus_rsp_err;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign stall         = (w_idle && w_access && !w_mis) ||
                          (r_state == ST_REQ) || (r_state == ST_WAIT);
   assign misaligned    = w_idle && w_access && w_mis;
   assign bus_err       = (r_state == ST_DONE) && r_err;
   assign rdata         = (r_state == ST_DONE) ? r_rdata : '0;
   assign bus_req_valid = r_valid;
   assign bus_addr      = r_addr;
   assign bus_we        = r_we;
   assign bus_wstrb     = r_wstrb;
   assign bus_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32_lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_lsu_bus_bridge
//  Brief    : Directed self-checking bench for rv32_lsu_bus_bridge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32_lsu_bus_bridge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] address;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        stall;
   logic        misaligned;
   logic        bus_err;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;
   logic        bus_rsp_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations gathered by do_access
   logic        o_done;
   int          o_stall_cnt;
   logic        o_mis;
   logic        o_valid_seen;
   logic        o_stable;
   logic [31:0] o_addr;
   logic        o_we;
   logic [3:0]  o_wstrb;
   logic [31:0] o_wdata;
   logic [31:0] o_rdata;
   logic        o_err;
   logic [31:0] o_leak;

   always #5 clk = ~clk;

   rv32_lsu_bus_bridge #(.AW(32), .DW(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .wdata         (wdata),
      .funct3        (funct3),
      .rdata         (rdata),
      .stall         (stall),
      .misaligned    (misaligned),
      .bus_err       (bus_err),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_addr      (bus_addr),
      .bus_we        (bus_we),
      .bus_wstrb     (bus_wstrb),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata),
      .bus_rsp_err   (bus_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Presents one instruction right after a rising edge, plays the slave
   // (ready after ready_dly held cycles, response the cycle after acceptance)
   // and records what the bridge did until the core is released.
   task automatic do_access(input logic mr, input logic mw, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3,
                            input int ready_dly, input logic [31:0] rsp,
                            input logic rsp_e, input logic wiggle);
      int   vcnt;
      logic accepted;
      MemRead = mr; MemWrite = mw; address = a; wdata = wd; funct3 = f3;
      o_done = 1'b0; o_stall_cnt = 0; o_mis = 1'b0; o_valid_seen = 1'b0;
      o_stable = 1'b1; o_rdata = '0; o_err = 1'b0; o_leak = '0;
      o_addr = '0; o_we = 1'b0; o_wstrb = '0; o_wdata = '0;
      vcnt = 0; accepted = 1'b0;
      for (int c = 0; c < 60 && !o_done; c++) begin
         @(negedge clk);
         if (!stall) begin
            o_done  = 1'b1;
            o_rdata = rdata;
            o_err   = bus_err;
            o_mis   = misaligned;
            if (bus_req_valid) o_valid_seen = 1'b1;
         end else begin
            o_stall_cnt++;
            o_leak = o_leak | rdata | {31'b0, bus_err} | {31'b0, misaligned};
            if (bus_req_valid) begin
               if (vcnt == 0) begin
                  o_addr = bus_addr; o_we = bus_we; o_wstrb = bus_wstrb; o_wdata = bus_wdata;
               end else if (bus_addr !== o_addr || bus_we !== o_we ||
                            bus_wstrb !== o_wstrb || bus_wdata !== o_wdata) begin
                  o_stable = 1'b0;
               end
               o_valid_seen = 1'b1;
               vcnt++;
               bus_req_ready = (vcnt > ready_dly);
               if (bus_req_ready) accepted = 1'b1;
               if (wiggle) begin
                  address = ~a; wdata = ~wd; funct3 = 3'b000; MemWrite = ~mw;
               end
            end else if (accepted) begin
               bus_req_ready = 1'b0;
               bus_rsp_valid = 1'b1;
               bus_rsp_rdata = rsp;
               bus_rsp_err   = rsp_e;
            end
         end
      end
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_rdata = '0;
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; address = '0; wdata = '0; funct3 = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      MemRead = 1'b0; MemWrite = 1'b0; address = '0; wdata = '0; funct3 = 3'b000;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus_req_valid, 0);
      check("rst_we",    bus_we, 0);
      check("rst_wstrb", bus_wstrb, 0);
      check("rst_addr",  bus_addr, 0);
      check("rst_wdata", bus_wdata, 0);
      check("rst_rdata", rdata, 0);
      check("rst_stall", stall, 0);
      check("rst_mis",   misaligned, 0);
      check("rst_err",   bus_err, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // T1: LW 0x100, immediate ready, response next cycle
      do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1'b0, 1'b0);
      check("t1_done",   o_done, 1);
      check("t1_stalls", o_stall_cnt, 3);
      check("t1_rdata",  o_rdata, 32'hDEADBEEF);
      check("t1_err",    o_err, 0);
      check("t1_addr",   o_addr, 32'h100);
      check("t1_we",     o_we, 0);
      check("t1_wstrb",  o_wstrb, 0);
      check("t1_leak",   o_leak, 0);
      @(negedge clk);
      check("t1_idle_rdata", rdata, 0);
      check("t1_idle_stall", stall, 0);
      @(posedge clk); #1;

      // T2: byte/half/word extraction and extension
      do_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 0, 32'h80FF_0000, 1'b0, 1'b0);
      check("t2_lb",   o_rdata, 32'hFFFFFF80);
      do_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 0, 32'h80FF_0000, 1'b0, 1'b0);
      check("t2_lbu",  o_rdata, 32'h00000080);
      check("t2_lbu_addr", o_addr, 32'h100);
      do_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 0, 32'h80FF_0000, 1'b0, 1'b0);
      check("t2_lh",   o_rdata, 32'hFFFF80FF);
      do_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 0, 32'h80FF_0000, 1'b0, 1'b0);
      check("t2_lhu",  o_rdata, 32'h000080FF);
      do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b001, 0, 32'h80FF_0000, 1'b0, 1'b0);
      check("t2_lh_lo", o_rdata, 32'h00000000);
      do_access(1'b1, 1'b0, 32'h108, 32'h0, 3'b111, 0, 32'h80FF_0000, 1'b0, 1'b0);
      check("t2_f3_111_word", o_rdata, 32'h80FF0000);
      check("t2_f3_111_addr", o_addr, 32'h108);

      // T3: store strobes and lane replication
      do_access(1'b0, 1'b1, 32'h102, 32'h123456AB, 3'b000, 0, 32'h0, 1'b0, 1'b0);
      check("t3_sb_wstrb", o_wstrb, 4'b0100);
      check("t3_sb_wdata", o_wdata, 32'hABABABAB);
      check("t3_sb_we",    o_we, 1);
      check("t3_sb_addr",  o_addr, 32'h100);
      do_access(1'b0, 1'b1, 32'h102, 32'hCAFE1234, 3'b001, 0, 32'h0, 1'b0, 1'b0);
      check("t3_sh_wstrb", o_wstrb, 4'b1100);
      check("t3_sh_wdata", o_wdata, 32'h12341234);
      do_access(1'b1, 1'b1, 32'h104, 32'h11223344, 3'b010, 0, 32'h0, 1'b0, 1'b0);
      check("t3_sw_both_we", o_we, 1);
      check("t3_sw_wstrb",   o_wstrb, 4'hF);
      check("t3_sw_wdata",   o_wdata, 32'h11223344);
      check("t3_sw_addr",    o_addr, 32'h104);

      // T4: misaligned rejection; byte at odd address still proceeds
      do_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 0, 32'h0, 1'b0, 1'b0);
      check("t4_lw_mis",    o_mis, 1);
      check("t4_lw_stalls", o_stall_cnt, 0);
      check("t4_lw_novalid", o_valid_seen, 0);
      check("t4_lw_rdata",  o_rdata, 0);
      @(negedge clk);
      check("t4_mis_pulse", misaligned, 0);
      @(posedge clk); #1;
      do_access(1'b0, 1'b1, 32'h103, 32'h5678, 3'b001, 0, 32'h0, 1'b0, 1'b0);
      check("t4_sh_mis",     o_mis, 1);
      check("t4_sh_novalid", o_valid_seen, 0);
      do_access(1'b0, 1'b1, 32'h103, 32'h000000C3, 3'b000, 0, 32'h0, 1'b0, 1'b0);
      check("t4_sb_nomis",  o_mis, 0);
      check("t4_sb_stalls", o_stall_cnt, 3);
      check("t4_sb_wstrb",  o_wstrb, 4'b1000);

      // T5: slow slave, core inputs wiggled during request, error response
      do_access(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 5, 32'h5555AAAA, 1'b1, 1'b1);
      check("t5_stalls", o_stall_cnt, 8);
      check("t5_stable", o_stable, 1);
      check("t5_err",    o_err, 1);
      check("t5_rdata",  o_rdata, 0);
      check("t5_addr",   o_addr, 32'h200);
      check("t5_we",     o_we, 0);
      @(negedge clk);
      check("t5_err_pulse", bus_err, 0);
      @(posedge clk); #1;

      // T6: reset during WAIT, stray response afterwards, then normal access
      MemRead = 1'b1; address = 32'h300; funct3 = 3'b010;
      @(negedge clk);
      @(negedge clk);
      check("t6_req_valid", bus_req_valid, 1);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0;
      check("t6_wait_stall", stall, 1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_valid", bus_req_valid, 0);
      MemRead = 1'b0; address = '0;
      @(negedge clk);
      check("t6_rst_stall", stall, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h12345678;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
      @(negedge clk);
      check("t6_stray_rdata", rdata, 0);
      check("t6_stray_stall", stall, 0);
      check("t6_stray_err",   bus_err, 0);
      @(posedge clk); #1;
      do_access(1'b1, 1'b0, 32'h304, 32'h0, 3'b010, 0, 32'h0BADF00D, 1'b0, 1'b0);
      check("t6_lw_rdata",  o_rdata, 32'h0BADF00D);
      check("t6_lw_stalls", o_stall_cnt, 3);
      check("t6_lw_addr",   o_addr, 32'h304);
      check("t6_lw_done",   o_done, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
